// File: rtl/ifu_mon_pkg.sv
// rtl/ifu_mon_pkg.sv - shared check indices, FSM state type and helpers for the IFU monitor
package ifu_mon_pkg;

  localparam int CHK_ALIGN      = 0;
  localparam int CHK_FULLEMPTY  = 1;
  localparam int CHK_FETCHFULL  = 2;
  localparam int CHK_TIMEOUT    = 3;
  localparam int CHK_VALIDFLUSH = 4;
  localparam int NUM_CHK        = 5;

  // Fetch-latency tracker states
  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    EXPIRED
  } state_t;

  // Index of the lowest set bit; 0 when nothing is set
  function automatic logic [2:0] lowest_fail(input logic [NUM_CHK-1:0] v);
    lowest_fail = 3'd0;
    for (int i = NUM_CHK - 1; i >= 0; i--) begin
      if (v[i]) lowest_fail = 3'(i);
    end
  endfunction

endpackage

// File: rtl/ifu_mon_counter.sv
// rtl/ifu_mon_counter.sv - saturating failure counter with same-cycle clear-then-increment
module ifu_mon_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  // Clear wins over the old value but not over this cycle's event; stop at all-ones
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= inc ? CNT_W'(1) : '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ifu_property_monitor.sv
// rtl/ifu_property_monitor.sv - five-check IFU protocol monitor with sticky flags, counters and irq
module ifu_property_monitor
  import ifu_mon_pkg::*;
#(
  parameter int                   ADDR_W        = 32,
  parameter int                   ALIGN_BITS    = 2,
  parameter int                   CNT_W         = 16,
  parameter int                   MAX_FETCH_LAT = 16,
  parameter logic [NUM_CHK-1:0]   FATAL_MASK    = 5'b11011
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        pc,
  input  logic                     instruction_valid,
  input  logic                     prefetch_full,
  input  logic                     prefetch_empty,
  input  logic                     mem_read,
  input  logic                     mem_ready,
  input  logic                     flush,
  input  logic [NUM_CHK-1:0]       chk_en,
  input  logic                     clear,
  output logic [NUM_CHK-1:0]       err_pulse,
  output logic [NUM_CHK-1:0]       err_sticky,
  output logic [NUM_CHK*CNT_W-1:0] fail_cnt,
  output logic [2:0]               first_fail_id,
  output logic [ADDR_W-1:0]        first_fail_pc,
  output logic                     first_valid,
  output logic                     irq
);

  // Wide enough to hold MAX_FETCH_LAT-1 with headroom
  localparam int LAT_W = $clog2(MAX_FETCH_LAT + 1);

  state_t             state;
  logic [LAT_W-1:0]   lat_cnt;
  logic               prev_full;
  logic               timeout_hit;
  logic [NUM_CHK-1:0] cond;
  logic [NUM_CHK-1:0] fire;
  logic [NUM_CHK-1:0] sticky_nxt;

  // Raw property conditions, then gated by the per-check enables
  always_comb begin
    cond        = '0;
    timeout_hit = (state == WAIT) && !mem_ready && !flush &&
                  (lat_cnt == LAT_W'(MAX_FETCH_LAT - 1));
    cond[CHK_ALIGN]      = instruction_valid && (pc[ALIGN_BITS-1:0] != '0);
    cond[CHK_FULLEMPTY]  = prefetch_full && prefetch_empty;
    cond[CHK_FETCHFULL]  = prev_full && mem_read && !flush;
    cond[CHK_TIMEOUT]    = timeout_hit;
    cond[CHK_VALIDFLUSH] = instruction_valid && flush;
    fire       = cond & chk_en;
    sticky_nxt = clear ? fire : (err_sticky | fire);
  end

  // Outstanding-read latency tracker; fires once per stalled request
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      lat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_read && !mem_ready && !flush) begin
            state   <= WAIT;
            lat_cnt <= LAT_W'(1);
          end
        end
        WAIT: begin
          if (mem_ready || flush) begin
            state   <= IDLE;
            lat_cnt <= '0;
          end else if (timeout_hit) begin
            state   <= EXPIRED;
            lat_cnt <= '0;
          end else begin
            lat_cnt <= lat_cnt + LAT_W'(1);
          end
        end
        EXPIRED: begin
          if (mem_ready || flush) state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          lat_cnt <= '0;
        end
      endcase
    end
  end

  // Previous-cycle buffer-full flag for the fetch-while-full check
  always_ff @(posedge clk) begin
    if (rst) prev_full <= 1'b0;
    else     prev_full <= prefetch_full;
  end

  // Registered pulses, sticky flags and interrupt
  always_ff @(posedge clk) begin
    if (rst) begin
      err_pulse  <= '0;
      err_sticky <= '0;
      irq        <= 1'b0;
    end else begin
      err_pulse  <= fire;
      err_sticky <= sticky_nxt;
      irq        <= |(sticky_nxt & FATAL_MASK);
    end
  end

  // First-failure capture; a clear re-arms it and a same-cycle event is captured
  always_ff @(posedge clk) begin
    if (rst) begin
      first_valid   <= 1'b0;
      first_fail_id <= '0;
      first_fail_pc <= '0;
    end else if ((clear || !first_valid) && (|fire)) begin
      first_valid   <= 1'b1;
      first_fail_id <= lowest_fail(fire);
      first_fail_pc <= pc;
    end else if (clear) begin
      first_valid   <= 1'b0;
      first_fail_id <= '0;
      first_fail_pc <= '0;
    end
  end

  for (genvar g = 0; g < NUM_CHK; g++) begin : g_cnt
    ifu_mon_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .clear (clear),
      .inc   (fire[g]),
      .cnt   (fail_cnt[g*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_ifu_property_monitor.sv
// tb/tb_ifu_property_monitor.sv - scoreboard bench for the IFU property monitor
module tb_ifu_property_monitor;

  localparam int         ADDR_W = 32;
  localparam int         CNT_W  = 4;
  localparam logic [4:0] FATAL  = 5'b11011;

  typedef struct packed {
    logic [4:0]       pulse;
    logic [4:0]       sticky;
    logic [5*CNT_W-1:0] cnt;
    logic             fv;
    logic [2:0]       id;
    logic [ADDR_W-1:0] fpc;
    logic             irq;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] pc;
  logic              instruction_valid;
  logic              prefetch_full;
  logic              prefetch_empty;
  logic              mem_read;
  logic              mem_ready;
  logic              flush;
  logic [4:0]        chk_en;
  logic              clear;
  logic [4:0]        err_pulse;
  logic [4:0]        err_sticky;
  logic [5*CNT_W-1:0] fail_cnt;
  logic [2:0]        first_fail_id;
  logic [ADDR_W-1:0] first_fail_pc;
  logic              first_valid;
  logic              irq;

  exp_t q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  logic [4:0]        es;
  logic [CNT_W-1:0]  ec [5];
  logic              ev;
  logic [2:0]        eid;
  logic [ADDR_W-1:0] epc;

  ifu_property_monitor #(
    .ADDR_W        (ADDR_W),
    .ALIGN_BITS    (2),
    .CNT_W         (CNT_W),
    .MAX_FETCH_LAT (4),
    .FATAL_MASK    (FATAL)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .pc                (pc),
    .instruction_valid (instruction_valid),
    .prefetch_full     (prefetch_full),
    .prefetch_empty    (prefetch_empty),
    .mem_read          (mem_read),
    .mem_ready         (mem_ready),
    .flush             (flush),
    .chk_en            (chk_en),
    .clear             (clear),
    .err_pulse         (err_pulse),
    .err_sticky        (err_sticky),
    .fail_cnt          (fail_cnt),
    .first_fail_id     (first_fail_id),
    .first_fail_pc     (first_fail_pc),
    .first_valid       (first_valid),
    .irq               (irq)
  );

  always #5 clk = ~clk;

  task automatic zero_exp();
    es  = '0;
    for (int i = 0; i < 5; i++) ec[i] = '0;
    ev  = 1'b0;
    eid = '0;
    epc = '0;
  endtask

  // Queue the response expected after the coming edge, then move to the next drive point
  task automatic push(input logic [4:0] p);
    exp_t e;
    e.pulse  = p;
    e.sticky = es;
    e.cnt    = {ec[4], ec[3], ec[2], ec[1], ec[0]};
    e.fv     = ev;
    e.id     = eid;
    e.fpc    = epc;
    e.irq    = |(es & FATAL);
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_assert++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp_v);
    end
  endtask

  // Monitor: compare DUT outputs against the oldest expectation after every edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("err_pulse",     64'(err_pulse),     64'(e.pulse));
        chk("err_sticky",    64'(err_sticky),    64'(e.sticky));
        chk("fail_cnt",      64'(fail_cnt),      64'(e.cnt));
        chk("first_valid",   64'(first_valid),   64'(e.fv));
        chk("first_fail_id", 64'(first_fail_id), 64'(e.id));
        chk("first_fail_pc", 64'(first_fail_pc), 64'(e.fpc));
        chk("irq",           64'(irq),           64'(e.irq));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: stimulus did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1; pc = '0; instruction_valid = 0; prefetch_full = 0; prefetch_empty = 0;
    mem_read = 0; mem_ready = 0; flush = 0; chk_en = 5'h1f; clear = 0;
    zero_exp();
    push(5'b0); push(5'b0);

    // Alignment check
    rst = 0; pc = 32'h100; instruction_valid = 1; push(5'b0);
    pc = 32'h102; es = 5'b00001; ec[0] = 1; ev = 1; eid = 0; epc = 32'h102; push(5'b00001);
    instruction_valid = 0; clear = 1; zero_exp(); push(5'b0);

    // Fetch while previously full: masked from irq, suppressed by flush
    clear = 0; pc = 32'h200; prefetch_full = 1; push(5'b0);
    prefetch_full = 0; mem_read = 1;
    es = 5'b00100; ec[2] = 1; ev = 1; eid = 2; epc = 32'h200; push(5'b00100);
    mem_read = 0; mem_ready = 1; push(5'b0);
    mem_ready = 0; clear = 1; zero_exp(); push(5'b0);
    clear = 0; prefetch_full = 1; push(5'b0);
    prefetch_full = 0; mem_read = 1; flush = 1; push(5'b0);
    mem_read = 0; flush = 0; push(5'b0);

    // Timeout: one pulse three edges after issue, then quiet while expired
    mem_read = 1;
    for (int k = 0; k < 10; k++) begin
      if (k == 3) begin
        es = 5'b01000; ec[3] = 1; ev = 1; eid = 3; epc = 32'h200; push(5'b01000);
      end else begin
        push(5'b0);
      end
    end
    mem_read = 0; mem_ready = 1; push(5'b0);
    mem_ready = 0; mem_read = 1;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) begin
        ec[3] = 2; push(5'b01000);
      end else begin
        push(5'b0);
      end
    end
    mem_read = 0; mem_ready = 1; push(5'b0);
    mem_ready = 0; clear = 1; zero_exp(); push(5'b0);

    // Flush in WAIT aborts the timeout
    clear = 0; mem_read = 1; push(5'b0); push(5'b0);
    mem_read = 0; flush = 1; push(5'b0);
    flush = 0; repeat (4) push(5'b0);

    // Counter saturation on full-and-empty
    prefetch_full = 1; prefetch_empty = 1;
    es = 5'b00010; ev = 1; eid = 1; epc = 32'h200;
    for (int k = 1; k <= 21; k++) begin
      ec[1] = (k > 15) ? 4'hF : 4'(k);
      push(5'b00010);
    end
    prefetch_full = 0; prefetch_empty = 0; push(5'b0);

    // Clear coinciding with a valid-during-flush violation
    clear = 1; instruction_valid = 1; flush = 1; pc = 32'h300;
    zero_exp(); es = 5'b10000; ec[4] = 1; ev = 1; eid = 4; epc = 32'h300; push(5'b10000);
    clear = 0; instruction_valid = 0; flush = 0; push(5'b0);

    // All checks disabled while every violation is driven
    clear = 1; zero_exp(); push(5'b0);
    clear = 0; chk_en = 5'b0; pc = 32'h101; instruction_valid = 1;
    prefetch_full = 1; prefetch_empty = 1; mem_read = 1; flush = 1; push(5'b0);
    flush = 0; push(5'b0);
    instruction_valid = 0; prefetch_full = 0; prefetch_empty = 0; repeat (4) push(5'b0);

    // Reset in the middle of WAIT restarts latency tracking
    chk_en = 5'h1f; mem_read = 0; mem_ready = 1; push(5'b0);
    mem_ready = 0; pc = 32'h101; instruction_valid = 1;
    es = 5'b00001; ec[0] = 1; ev = 1; eid = 0; epc = 32'h101; push(5'b00001);
    instruction_valid = 0; mem_read = 1; push(5'b0); push(5'b0);
    rst = 1; zero_exp(); push(5'b0);
    rst = 0; pc = 32'h400;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) begin
        es = 5'b01000; ec[3] = 1; ev = 1; eid = 3; epc = 32'h400; push(5'b01000);
      end else begin
        push(5'b0);
      end
    end
    mem_read = 0; mem_ready = 1; push(5'b0);
    mem_ready = 0;

    for (int t = 0; t < 5 && q.size() != 0; t++) @(negedge clk);
    n_assert++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
